// File: rtl/sd_clk_switch_seq.sv
// Clock Control sequencer in front of the SD card clock divider: brings the internal
// clock up, gates the card clock, and performs glitch-free divisor switches once the bus is idle.
module sd_clk_switch_seq #(
  parameter int GATE_CYCLES    = 8,
  parameter int RST_CYCLES     = 2,
  parameter int STABLE_TIMEOUT = 4095,
  parameter int TW             = 12
) (
  input  logic       AXI_CLOCK,
  input  logic       AXI_RST,
  input  logic       int_clk_en_i,
  input  logic       sd_clk_en_i,
  input  logic [7:0] freq_sel_i,
  input  logic       freq_wr_i,
  input  logic       bus_busy_i,
  input  logic       div_stable_i,
  output logic [7:0] div_o,
  output logic       div_rst_o,
  output logic       sd_clk_gate_o,
  output logic       int_clk_stable_o,
  output logic       switch_done_o,
  output logic       busy_o,
  output logic       err_timeout_o
);

  typedef enum logic [3:0] {
    S_OFF, S_WAIT_ST, S_STABLE, S_RUN, S_DRAIN, S_GATE, S_RELOAD, S_WAIT_SW, S_POST
  } state_t;

  localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_TIMEOUT);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          pend;
  logic [7:0]    pend_div;
  logic          en_q;
  logic          en_rise, wr_take, consume, timeout_hit, post_done;
  logic          gate_nxt, rst_nxt, stable_nxt, busy_nxt;

  assign en_rise = int_clk_en_i & ~en_q;
  // Rewriting the current divisor is a no-op only when no switch is in flight.
  assign wr_take = freq_wr_i & ((freq_sel_i != div_o) | busy_o);

  always_ff @(posedge AXI_CLOCK or posedge AXI_RST) begin
    if (AXI_RST) begin
      state            <= S_OFF;
      timer            <= '0;
      pend             <= 1'b0;
      pend_div         <= 8'h7D;
      en_q             <= 1'b0;
      div_o            <= 8'h7D;
      div_rst_o        <= 1'b1;
      sd_clk_gate_o    <= 1'b0;
      int_clk_stable_o <= 1'b0;
      switch_done_o    <= 1'b0;
      busy_o           <= 1'b0;
      err_timeout_o    <= 1'b0;
    end else begin
      state            <= state_nxt;
      // Every state that measures time starts counting from its entry.
      timer            <= (state_nxt != state) ? '0 : timer + TW'(1);
      en_q             <= int_clk_en_i;
      div_rst_o        <= rst_nxt;
      sd_clk_gate_o    <= gate_nxt;
      int_clk_stable_o <= stable_nxt;
      switch_done_o    <= post_done;
      busy_o           <= busy_nxt;
      if (consume) div_o <= pend_div;
      if (wr_take) begin
        pend     <= 1'b1;
        pend_div <= freq_sel_i;
      end else if (consume) begin
        pend <= 1'b0;
      end
      if (timeout_hit)  err_timeout_o <= 1'b1;
      else if (en_rise) err_timeout_o <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    post_done   = 1'b0;
    case (state)
      // A latched timeout holds the sequencer off until the enable is toggled.
      S_OFF:     if (int_clk_en_i && (!err_timeout_o || en_rise)) state_nxt = S_WAIT_ST;
      S_WAIT_ST: if (div_stable_i) state_nxt = S_STABLE;
                 else if (timer == STABLE_LAST) begin
                   state_nxt   = S_OFF;
                   timeout_hit = 1'b1;
                 end
      S_STABLE:  if (pend) state_nxt = S_GATE;
                 else if (sd_clk_en_i) state_nxt = S_RUN;
      S_RUN:     if (!sd_clk_en_i) state_nxt = S_STABLE;
                 else if (pend) state_nxt = S_DRAIN;
      S_DRAIN:   if (!bus_busy_i) state_nxt = S_GATE;
      S_GATE:    if (timer == GATE_LAST) state_nxt = S_RELOAD;
      S_RELOAD:  if (timer == RST_LAST) state_nxt = S_WAIT_SW;
      S_WAIT_SW: if (div_stable_i) state_nxt = S_POST;
                 else if (timer == STABLE_LAST) begin
                   state_nxt   = S_OFF;
                   timeout_hit = 1'b1;
                 end
      S_POST:    if (timer == GATE_LAST) begin
                   post_done = 1'b1;
                   if (pend)             state_nxt = S_GATE;
                   else if (sd_clk_en_i) state_nxt = S_RUN;
                   else                  state_nxt = S_STABLE;
                 end
      default:   state_nxt = S_OFF;
    endcase
    if (!int_clk_en_i) begin
      state_nxt   = S_OFF;
      timeout_hit = 1'b0;
      post_done   = 1'b0;
    end
  end

  // Outputs are a function of the state being entered, so they land with the state register.
  always_comb begin
    gate_nxt   = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
    rst_nxt    = (state_nxt == S_OFF) || (state_nxt == S_GATE) || (state_nxt == S_RELOAD);
    stable_nxt = (state_nxt == S_STABLE) || (state_nxt == S_RUN) ||
                 (state_nxt == S_DRAIN)  || (state_nxt == S_POST);
    busy_nxt   = !((state_nxt == S_OFF) || (state_nxt == S_STABLE) || (state_nxt == S_RUN));
    consume    = pend && (((state == S_OFF) && (state_nxt == S_WAIT_ST)) ||
                          ((state != S_GATE) && (state_nxt == S_GATE)));
  end

endmodule
